lr35902_bg_fetch: RTL and testbench

Background tile fetcher for the PPU. It drives the PPU-side VRAM port: the PPU address, a read strobe and the PPU-active select, and it consumes the VRAM read data. Per scanline it walks the BG tile map, fetches tile number, low bitplane and high bitplane bytes for each tile, and hands each 8-pixel row to the pixel FIFO over a valid/ready handshake.

---
 rtl/lr35902_bg_fetch.sv | 170 +++++++++++++++++
 tb/tb_lr35902_bg_fetch.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lr35902_bg_fetch.sv
// Background tile fetcher: walks the BG map per scanline and hands 8-pixel rows to the pixel FIFO.
// Optional macro LR35902_BG_FETCH_BITREV_EN presents pixel bytes LSB-first (bit 0 = leftmost pixel).
module lr35902_bg_fetch #(
    parameter int TILES_PER_LINE = 21
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        bg_map_sel,
    input  logic        tile_data_sel,
    input  logic [7:0]  scx,
    input  logic [7:0]  scy,
    input  logic [7:0]  ly,
    output logic [12:0] vadr,
    output logic        vread,
    input  logic [7:0]  vdata,
    output logic        busy,
    output logic [7:0]  pix_lo,
    output logic [7:0]  pix_hi,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        line_done
);
    typedef enum logic [2:0] {IDLE, NUM0, NUM1, LO0, LO1, HI0, HI1, PUSH} state_t;

    localparam logic [4:0] LAST_TILE = 5'(TILES_PER_LINE - 1);

    state_t      state, state_n;
    logic [4:0]  tile_x, tile_x_n;
    logic [4:0]  scx_t, scx_t_n;
    logic [7:0]  yy, yy_n;
    logic        map_sel, map_sel_n;
    logic        data_sel, data_sel_n;
    logic [12:0] vadr_n;
    logic        vread_n, busy_n, pix_valid_n, line_done_n;
    logic [7:0]  pix_lo_n, pix_hi_n;

    logic [7:0]  yy_start;
    logic [4:0]  col_next;
    logic [2:0]  scx_fine_unused;

    // Fine scroll is applied downstream by the pixel FIFO.
    assign scx_fine_unused = scx[2:0];
    assign yy_start        = scy + ly;
    assign col_next        = scx_t + tile_x + 5'd1;

    function automatic logic [12:0] map_adr(input logic sel, input logic [7:0] y, input logic [4:0] col);
        return (sel ? 13'h1C00 : 13'h1800) + {3'b000, y[7:3], col};
    endfunction

    // Signed mode: 0x1000 + sext(num)*16, wrapping in 13 bits.
    function automatic logic [12:0] row_adr(input logic usel, input logic [7:0] num, input logic [2:0] row);
        logic [12:0] base;
        base = usel ? {1'b0, num, 4'b0000} : 13'h1000 + {num[7], num, 4'b0000};
        return base + {9'd0, row, 1'b0};
    endfunction

    function automatic logic [7:0] pix_order(input logic [7:0] b);
`ifdef LR35902_BG_FETCH_BITREV_EN
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
`else
        return b;
`endif
    endfunction

    always_comb begin
        state_n     = state;
        tile_x_n    = tile_x;
        scx_t_n     = scx_t;
        yy_n        = yy;
        map_sel_n   = map_sel;
        data_sel_n  = data_sel;
        vadr_n      = vadr;
        vread_n     = 1'b0;
        busy_n      = busy;
        pix_valid_n = 1'b0;
        line_done_n = 1'b0;
        pix_lo_n    = pix_lo;
        pix_hi_n    = pix_hi;
        // Outputs are registered, so each branch computes what the next state presents.
        if (start) begin
            map_sel_n  = bg_map_sel;
            data_sel_n = tile_data_sel;
            scx_t_n    = scx[7:3];
            yy_n       = yy_start;
            tile_x_n   = 5'd0;
            state_n    = NUM0;
            vadr_n     = map_adr(bg_map_sel, yy_start, scx[7:3]);
            vread_n    = 1'b1;
            busy_n     = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    vadr_n = 13'd0;
                    busy_n = 1'b0;
                end
                NUM0: state_n = NUM1;
                NUM1: begin
                    // vdata is the tile number here; it only feeds the row address.
                    vadr_n  = row_adr(data_sel, vdata, yy[2:0]);
                    vread_n = 1'b1;
                    state_n = LO0;
                end
                LO0: state_n = LO1;
                LO1: begin
                    pix_lo_n = pix_order(vdata);
                    vadr_n   = vadr + 13'd1;
                    vread_n  = 1'b1;
                    state_n  = HI0;
                end
                HI0: state_n = HI1;
                HI1: begin
                    pix_hi_n    = pix_order(vdata);
                    pix_valid_n = 1'b1;
                    state_n     = PUSH;
                end
                PUSH: begin
                    if (!pix_ready) begin
                        pix_valid_n = 1'b1;
                    end else if (tile_x == LAST_TILE) begin
                        state_n     = IDLE;
                        line_done_n = 1'b1;
                        busy_n      = 1'b0;
                        vadr_n      = 13'd0;
                    end else begin
                        tile_x_n = tile_x + 5'd1;
                        state_n  = NUM0;
                        vadr_n   = map_adr(map_sel, yy, col_next);
                        vread_n  = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tile_x    <= 5'd0;
            scx_t     <= 5'd0;
            yy        <= 8'd0;
            map_sel   <= 1'b0;
            data_sel  <= 1'b0;
            vadr      <= 13'd0;
            vread     <= 1'b0;
            busy      <= 1'b0;
            pix_lo    <= 8'd0;
            pix_hi    <= 8'd0;
            pix_valid <= 1'b0;
            line_done <= 1'b0;
        end else begin
            state     <= state_n;
            tile_x    <= tile_x_n;
            scx_t     <= scx_t_n;
            yy        <= yy_n;
            map_sel   <= map_sel_n;
            data_sel  <= data_sel_n;
            vadr      <= vadr_n;
            vread     <= vread_n;
            busy      <= busy_n;
            pix_lo    <= pix_lo_n;
            pix_hi    <= pix_hi_n;
            pix_valid <= pix_valid_n;
            line_done <= line_done_n;
        end
    end
endmodule

// File: tb/tb_lr35902_bg_fetch.sv
// Scoreboard bench for lr35902_bg_fetch: a per-line reference model predicts VRAM reads and pixel rows.
module tb_lr35902_bg_fetch;
    localparam int N = 21;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        bg_map_sel = 1'b0, tile_data_sel = 1'b1;
    logic [7:0]  scx = 8'd0, scy = 8'd0, ly = 8'd0;
    logic [12:0] vadr;
    logic        vread;
    logic [7:0]  vdata;
    logic        busy;
    logic [7:0]  pix_lo, pix_hi;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic        line_done;

    logic [7:0]  mem [0:8191];
    assign vdata = mem[vadr];

    lr35902_bg_fetch #(.TILES_PER_LINE(N)) dut (
        .clk(clk), .reset(reset), .start(start), .bg_map_sel(bg_map_sel),
        .tile_data_sel(tile_data_sel), .scx(scx), .scy(scy), .ly(ly),
        .vadr(vadr), .vread(vread), .vdata(vdata), .busy(busy),
        .pix_lo(pix_lo), .pix_hi(pix_hi), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .line_done(line_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    int xfers = 0, last_xfer_cyc = 0, done_cnt = 0, done_cyc = 0;
    int s0 = 0;
    bit rnd_ready = 1'b0;
    bit held = 1'b0;
    logic [15:0] held_val;
    int adr_q[$];
    int pix_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int order(input int b);
`ifdef LR35902_BG_FETCH_BITREV_EN
        int r = 0;
        for (int i = 0; i < 8; i++) if (b & (1 << i)) r |= (1 << (7 - i));
        return r;
`else
        return b;
`endif
    endfunction

    // Reference: expected read addresses and pixel rows for one whole line.
    task automatic expect_line(input int msel, input int dsel, input int sx, input int sy, input int l);
        int yv, col, ma, num, sn, base, a, ha;
        yv = (sy + l) % 256;
        for (int t = 0; t < N; t++) begin
            col  = (sx / 8 + t) % 32;
            ma   = (msel ? 'h1C00 : 'h1800) + (yv / 8) * 32 + col;
            num  = mem[ma];
            sn   = (num >= 128) ? num - 256 : num;
            base = dsel ? num * 16 : 'h1000 + sn * 16;
            a    = (base + (yv % 8) * 2) % 8192;
            ha   = (a + 1) % 8192;
            adr_q.push_back(ma);
            adr_q.push_back(a);
            adr_q.push_back(ha);
            pix_q.push_back(order(mem[ha]) * 256 + order(mem[a]));
        end
    endtask

    // Monitor: pops expectations whenever the DUT strobes VRAM or transfers a row.
    always @(negedge clk) begin
        if (!reset) begin
            if (vread) begin
                if (adr_q.size() == 0) check("vread_unexpected", 1, 0);
                else check("vread_adr", int'(vadr), adr_q.pop_front());
                check("vread_busy", int'(busy), 1);
            end
            if (pix_valid) begin
                check("push_no_vread", int'(vread), 0);
                check("push_busy", int'(busy), 1);
                if (held) check("hold_stable", int'({pix_hi, pix_lo}), int'(held_val));
            end
            if (pix_valid && pix_ready) begin
                if (pix_q.size() == 0) check("push_unexpected", 1, 0);
                else check("pix_row", int'({pix_hi, pix_lo}), pix_q.pop_front());
                xfers++;
                last_xfer_cyc = cyc;
                held = 1'b0;
            end else if (pix_valid) begin
                held = 1'b1;
                held_val = {pix_hi, pix_lo};
            end else begin
                held = 1'b0;
            end
            if (line_done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_not_busy", int'(busy), 0);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) pix_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    endtask

    // Pulses start in cycle 0 (s0); returns at cycle 1. Later input changes must be ignored.
    task automatic do_start(input int msel, input int dsel, input int sx, input int sy, input int l);
        bg_map_sel = 1'(msel); tile_data_sel = 1'(dsel);
        scx = 8'(sx); scy = 8'(sy); ly = 8'(l);
        start = 1'b1;
        s0 = cyc;
        tick(1);
        start = 1'b0;
        adr_q.delete();
        pix_q.delete();
        held = 1'b0;
        expect_line(msel, dsel, sx, sy, l);
        bg_map_sel = 1'($urandom); tile_data_sel = 1'($urandom);
        scx = 8'($urandom); scy = 8'($urandom); ly = 8'($urandom);
    endtask

    task automatic wait_done();
        int d0 = done_cnt;
        int i = 0;
        while (done_cnt == d0 && i < 3000) begin
            tick(1);
            i++;
        end
        if (done_cnt == d0) check("line_timeout", 0, 1);
    endtask

    initial begin
        int x0, d0, tmo;
        fill_mem();
        tick(2);
        check("rst_vadr", int'(vadr), 0);
        check("rst_vread", int'(vread), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(pix_valid), 0);
        check("rst_done", int'(line_done), 0);
        check("rst_pix", int'({pix_hi, pix_lo}), 0);
        reset = 1'b0;
        tick(1);

        // Test 1 + full line timing.
        mem['h1800] = 8'h05; mem['h0050] = 8'h3C; mem['h0051] = 8'h7E;
        x0 = xfers; d0 = done_cnt;
        do_start(0, 1, 0, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            check("t1_vread", int'(vread), int'(k == 1 || k == 3 || k == 5));
            if (k == 1) check("t1_map_adr", int'(vadr), 'h1800);
            if (k == 3) check("t1_lo_adr", int'(vadr), 'h0050);
            if (k == 5) check("t1_hi_adr", int'(vadr), 'h0051);
            if (k == 7) begin
                check("t1_valid", int'(pix_valid), 1);
                check("t1_pix", int'({pix_hi, pix_lo}), 'h7E3C);
            end
            if (k < 7) tick(1);
        end
        wait_done();
        check("t5_xfers", xfers - x0, N);
        check("t5_last_xfer_cyc", last_xfer_cyc - s0, 147);
        check("t5_done_cyc", done_cyc - s0, 148);
        check("t5_done_once", done_cnt - d0, 1);
        check("t5_done_pulse", int'(line_done), 0);
        check("t5_idle_busy", int'(busy), 0);
        check("t5_queues_empty", adr_q.size() + pix_q.size(), 0);

        // Test 2: signed tile data.
        fill_mem();
        mem['h1800] = 8'h80; mem['h1801] = 8'h7F;
        do_start(0, 0, 0, 0, 3);
        tick(2);
        check("t2_lo_0x80", int'(vadr), 'h0806);
        tick(2);
        check("t2_hi_0x80", int'(vadr), 'h0807);
        tick(5);
        check("t2_lo_0x7f", int'(vadr), 'h17F6);
        wait_done();

        // Tests 3 + 4: column wrap, yy wrap, backpressure hold.
        fill_mem();
        pix_ready = 1'b0;
        do_start(1, 1, 'hF8, 'hFF, 1);
        check("t3_map_first", int'(vadr), 'h1C1F);
        tick(6);
        for (int k = 7; k <= 11; k++) begin
            check("t4_hold_valid", int'(pix_valid), 1);
            check("t4_hold_vread", int'(vread), 0);
            check("t4_hold_busy", int'(busy), 1);
            if (k < 11) tick(1);
        end
        pix_ready = 1'b1;
        tick(1);
        check("t4_next_vread", int'(vread), 1);
        check("t3_map_wrap", int'(vadr), 'h1C00);
        wait_done();

        // Test 6a: reset during HI0.
        fill_mem();
        do_start(0, 1, 'h30, 'h12, 'h40);
        tick(4);
        reset = 1'b1;
        tick(1);
        check("t6_rst_vread", int'(vread), 0);
        check("t6_rst_valid", int'(pix_valid), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_vadr", int'(vadr), 0);
        reset = 1'b0;
        adr_q.delete(); pix_q.delete(); held = 1'b0;
        tick(2);
        check("t6_idle_after_rst", int'(busy), 0);

        // Test 6b: restart mid-line at tile 4 (while in LO0).
        x0 = xfers; d0 = done_cnt;
        do_start(1, 0, 'h55, 'h21, 'h07);
        tmo = 0;
        while (xfers - x0 < 4 && tmo < 200) begin tick(1); tmo++; end
        check("t6_reach_tile4", xfers - x0, 4);
        tick(2);
        do_start(0, 1, 'h0B, 'h90, 'h33);
        check("t6_abort_vread", int'(vread), 1);
        check("t6_abort_map", int'(vadr), 'h1800 + (('h90 + 'h33) % 256 / 8) * 32 + 1);
        check("t6_abort_valid", int'(pix_valid), 0);
        wait_done();
        check("t6_abort_xfers", xfers - x0, 4 + N);
        check("t6_abort_done_once", done_cnt - d0, 1);

        // Test 7: bit order of a single-pixel low byte.
        fill_mem();
        mem['h1800] = 8'h02; mem['h0020] = 8'h01;
        do_start(0, 1, 0, 0, 0);
        tick(6);
`ifdef LR35902_BG_FETCH_BITREV_EN
        check("t7_pix_lo_order", int'(pix_lo), 'h80);
`else
        check("t7_pix_lo_order", int'(pix_lo), 'h01);
`endif
        wait_done();

        // Randomized lines with random backpressure.
        rnd_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            fill_mem();
            x0 = xfers;
            do_start(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                     int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 153)));
            wait_done();
            check("rnd_xfers", xfers - x0, N);
            check("rnd_queues_empty", adr_q.size() + pix_q.size(), 0);
            tick(int'($urandom_range(0, 3)));
        end
        rnd_ready = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
